// File: rtl/light_monitor.sv
// Traffic-light lamp monitor: debounces the r/g/b drive into an accepted color,
// times each color and flags illegal sequences. Optional timeout via LIGHT_MON_TIMEOUT_EN.
module light_monitor #(
    parameter int unsigned FILTER    = 2,
    parameter int unsigned MAX_DWELL = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] r,
    input  logic [3:0] g,
    input  logic [3:0] b,
    output logic [2:0] color,
    output logic [7:0] dwell,
    output logic [7:0] last_dwell,
    output logic       seq_err,
    output logic [7:0] err_cnt,
    output logic       timeout
);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_RED     = 3'd1,
        ST_GREEN   = 3'd2,
        ST_YELLOW  = 3'd3,
        ST_INVALID = 3'd4
    } state_e;

    localparam logic [3:0] FILT_MAX  = 4'(FILTER);
    localparam logic [3:0] FILT_LAST = 4'(FILTER - 1);

    if (FILTER < 1 || FILTER > 15 || MAX_DWELL > 255) begin : g_bad_param
        $error("light_monitor: FILTER must be 1..15 and MAX_DWELL at most 255");
    end

    logic [3:0] r_q, g_q, b_q;
    state_e     state_q, state_d;
    state_e     cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] dwell_q, dwell_d;
    logic [7:0] last_dwell_q, last_dwell_d;
    logic       seq_err_q, seq_err_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    state_e     dec;
    logic       commit;
    logic [7:0] dwell_inc;

    function automatic state_e decode(input logic [3:0] rv, input logic [3:0] gv,
                                      input logic [3:0] bv);
        state_e res;
        if (bv != 4'h0) begin
            res = ST_INVALID;
        end else if (rv == 4'hF && gv == 4'h0) begin
            res = ST_RED;
        end else if (rv == 4'h0 && gv == 4'hF) begin
            res = ST_GREEN;
        end else if (rv == 4'hF && gv == 4'hF) begin
            res = ST_YELLOW;
        end else if (rv == 4'h0 && gv == 4'h0) begin
            res = ST_OFF;
        end else begin
            res = ST_INVALID;
        end
        return res;
    endfunction

    function automatic logic is_legal(input state_e from, input state_e to);
        logic ok;
        case (to)
            ST_OFF:    ok = 1'b1;
            ST_RED:    ok = (from == ST_YELLOW) || (from == ST_OFF);
            ST_GREEN:  ok = (from == ST_RED);
            ST_YELLOW: ok = (from == ST_GREEN);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Input capture register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= 4'h0;
            g_q <= 4'h0;
            b_q <= 4'h0;
        end else begin
            r_q <= r;
            g_q <= g;
            b_q <= b;
        end
    end

    // Debounce filter and commit decision; commit fires on the edge the count reaches FILTER
    always_comb begin
        dec    = decode(r_q, g_q, b_q);
        commit = (dec == cand_q) && (cand_q != state_q) && (cnt_q >= FILT_LAST);
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (dec != cand_q) begin
            cand_d = dec;
            cnt_d  = 4'd0;
        end else if (cnt_q < FILT_MAX) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // FSM next state and sequence check
    always_comb begin
        state_d   = state_q;
        seq_err_d = 1'b0;
        if (commit) begin
            state_d   = cand_q;
            seq_err_d = ~is_legal(state_q, cand_q);
        end else begin
            state_d = state_q;
        end
    end

    // Dwell timing and error counting; a tick coinciding with a commit is dropped
    always_comb begin
        dwell_inc    = (dwell_q == 8'hFF) ? 8'hFF : dwell_q + 8'd1;
        dwell_d      = dwell_q;
        last_dwell_d = last_dwell_q;
        err_cnt_d    = err_cnt_q;
        if (commit) begin
            last_dwell_d = dwell_q;
            dwell_d      = 8'd0;
        end else if (tick) begin
            dwell_d = dwell_inc;
        end else begin
            dwell_d = dwell_q;
        end
        if (seq_err_d && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_OFF;
            cand_q       <= ST_OFF;
            cnt_q        <= 4'd0;
            dwell_q      <= 8'd0;
            last_dwell_q <= 8'd0;
            seq_err_q    <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            dwell_q      <= dwell_d;
            last_dwell_q <= last_dwell_d;
            seq_err_q    <= seq_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

`ifdef LIGHT_MON_TIMEOUT_EN
    localparam logic [8:0] MAXD = 9'(MAX_DWELL);
    logic timeout_q, timeout_d;

    // Sticky timeout, set by a tick pushing dwell past the limit in an active color
    always_comb begin
        timeout_d = timeout_q;
        if (commit) begin
            timeout_d = 1'b0;
        end else if (tick && (state_q == ST_RED || state_q == ST_GREEN ||
                              state_q == ST_YELLOW) && ({1'b0, dwell_inc} > MAXD)) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // Timeout register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign color      = state_q;
    assign dwell      = dwell_q;
    assign last_dwell = last_dwell_q;
    assign seq_err    = seq_err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_light_monitor.sv
// Bench for light_monitor: directed scenarios plus random lamp drive, checked
// against a history-based reference model of the accepted color and timers.
module tb_light_monitor;

    localparam int FILTER = 2;
`ifdef LIGHT_MON_TIMEOUT_EN
    localparam int MAXD = 3;
`else
    localparam int MAXD = 30;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [3:0] r, g, b;
    logic [2:0] color;
    logic [7:0] dwell, last_dwell, err_cnt;
    logic       seq_err, timeout;

    int checks = 0;
    int errors = 0;

    int m_color, m_dwell, m_last, m_seq, m_err, m_to;
    int hist[$];

    light_monitor #(.FILTER(FILTER), .MAX_DWELL(MAXD)) dut (
        .clk(clk), .rst(rst), .tick(tick), .r(r), .g(g), .b(b),
        .color(color), .dwell(dwell), .last_dwell(last_dwell),
        .seq_err(seq_err), .err_cnt(err_cnt), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic int dec(input logic [3:0] rr, input logic [3:0] gg, input logic [3:0] bb);
        if (rr == 4'hF && gg == 4'h0 && bb == 4'h0) return 1;
        if (rr == 4'h0 && gg == 4'hF && bb == 4'h0) return 2;
        if (rr == 4'hF && gg == 4'hF && bb == 4'h0) return 3;
        if (rr == 4'h0 && gg == 4'h0 && bb == 4'h0) return 0;
        return 4;
    endfunction

    function automatic bit legal(input int from, input int to);
        if (to == 0) return 1'b1;
        return (from == 1 && to == 2) || (from == 2 && to == 3) ||
               (from == 3 && to == 1) || (from == 0 && to == 1);
    endfunction

    task automatic model_reset();
        m_color = 0; m_dwell = 0; m_last = 0; m_seq = 0; m_err = 0; m_to = 0;
        hist = {};
        for (int i = 0; i <= FILTER; i++) hist.push_back(0);
    endtask

    // A color is accepted once the last FILTER+1 captured samples all agree on it.
    task automatic model_edge(input logic tk, input int sample);
        int  c;
        bit  same;
        c = hist[0];
        same = 1'b1;
        foreach (hist[i]) if (hist[i] != c) same = 1'b0;
        if (same && c != m_color) begin
            m_seq = legal(m_color, c) ? 0 : 1;
            if (m_seq == 1 && m_err < 255) m_err++;
            m_last  = m_dwell;
            m_dwell = 0;
            m_to    = 0;
            m_color = c;
        end else begin
            m_seq = 0;
            if (tk) begin
                if (m_dwell < 255) m_dwell++;
`ifdef LIGHT_MON_TIMEOUT_EN
                if (m_color >= 1 && m_color <= 3 && m_dwell > MAXD) m_to = 1;
`endif
            end
        end
        void'(hist.pop_front());
        hist.push_back(sample);
    endtask

    task automatic chk(input string tag, input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s %s got %0d expected %0d", tag, nm, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk(tag, "color", {29'd0, color}, m_color);
        chk(tag, "dwell", {24'd0, dwell}, m_dwell);
        chk(tag, "last_dwell", {24'd0, last_dwell}, m_last);
        chk(tag, "seq_err", {31'd0, seq_err}, m_seq);
        chk(tag, "err_cnt", {24'd0, err_cnt}, m_err);
        chk(tag, "timeout", {31'd0, timeout}, m_to);
    endtask

    task automatic apply(input logic tk, input logic [3:0] rr, input logic [3:0] gg,
                         input logic [3:0] bb, input string tag);
        tick = tk; r = rr; g = gg; b = bb;
        @(posedge clk);
        model_edge(tk, dec(rr, gg, bb));
        #1;
        check_all(tag);
    endtask

    task automatic step(input logic tk, input logic [3:0] rr, input logic [3:0] gg,
                        input logic [3:0] bb, input string tag);
        @(negedge clk);
        apply(tk, rr, gg, bb, tag);
    endtask

    task automatic hold(input int n, input logic tk, input logic [3:0] rr,
                        input logic [3:0] gg, input logic [3:0] bb, input string tag);
        for (int i = 0; i < n; i++) step(tk, rr, gg, bb, tag);
    endtask

    task automatic pat(input int c, output logic [3:0] rr, output logic [3:0] gg,
                       output logic [3:0] bb);
        case (c)
            0: begin rr = 4'h0; gg = 4'h0; bb = 4'h0; end
            1: begin rr = 4'hF; gg = 4'h0; bb = 4'h0; end
            2: begin rr = 4'h0; gg = 4'hF; bb = 4'h0; end
            3: begin rr = 4'hF; gg = 4'hF; bb = 4'h0; end
            default: begin
                rr = 4'($urandom_range(0, 15));
                gg = 4'($urandom_range(0, 15));
                bb = 4'($urandom_range(0, 15));
            end
        endcase
    endtask

    initial begin
        logic [3:0] rr, gg, bb;
        int         p, len, nxt;
        logic       tk;

        rst = 1'b0; tick = 1'b0; r = 4'h0; g = 4'h0; b = 4'h0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;
        apply(1'b0, 4'h0, 4'h0, 4'h0, "release");
        hold(8, 1'b0, 4'h0, 4'h0, 4'h0, "idle");

        // RED accepted on the FILTER+1-th edge after it is first captured
        hold(3, 1'b0, 4'hF, 4'h0, 4'h0, "red_filter");
        chk("red_latency", "color_before", {29'd0, color}, 32'd0);
        step(1'b0, 4'hF, 4'h0, 4'h0, "red_commit");
        chk("red_latency", "color_after", {29'd0, color}, 32'd1);
        hold(5, 1'b1, 4'hF, 4'h0, 4'h0, "red_ticks");
        hold(4, 1'b0, 4'h0, 4'hF, 4'h0, "green");
        chk("red_green", "last_dwell", {24'd0, last_dwell}, 32'd5);
        hold(4, 1'b0, 4'hF, 4'hF, 4'h0, "yellow");
        hold(4, 1'b1, 4'hF, 4'hF, 4'h0, "yellow_ticks");
        hold(4, 1'b0, 4'hF, 4'h0, 4'h0, "yellow_red");
        chk("yellow_red", "timeout", {31'd0, timeout}, 32'd0);

        // Short glitches toward GREEN must be filtered out
        step(1'b1, 4'h0, 4'hF, 4'h0, "glitch1");
        hold(3, 1'b1, 4'hF, 4'h0, 4'h0, "glitch1_back");
        hold(2, 1'b0, 4'h0, 4'hF, 4'h0, "glitch2");
        hold(3, 1'b0, 4'hF, 4'h0, 4'h0, "glitch2_back");
        chk("glitch", "color", {29'd0, color}, 32'd1);

        hold(4, 1'b0, 4'h0, 4'hF, 4'h0, "green2");
        hold(4, 1'b0, 4'hF, 4'h0, 4'h0, "green_red_err");
        chk("green_red", "err_cnt", {24'd0, err_cnt}, 32'd1);
        hold(4, 1'b0, 4'hF, 4'h0, 4'hF, "invalid");
        chk("invalid", "color", {29'd0, color}, 32'd4);
        chk("invalid", "err_cnt", {24'd0, err_cnt}, 32'd2);

        // Reset asserted just before an edge carrying both a commit and a tick
        hold(3, 1'b0, 4'h0, 4'hF, 4'h0, "pre_rst");
        @(negedge clk);
        tick = 1'b1;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_hold1");
        @(posedge clk);
        #1;
        check_all("rst_hold2");
        @(negedge clk);
        rst = 1'b1;
        apply(1'b0, 4'h0, 4'h0, 4'h0, "rst_release");
        hold(4, 1'b1, 4'hF, 4'h0, 4'h0, "post_rst_red");

        // Random lamp drive
        for (int s = 0; s < 80; s++) begin
            p = $urandom_range(0, 5);
            if (p == 5) begin
                case (m_color)
                    0: nxt = 1;
                    1: nxt = 2;
                    2: nxt = 3;
                    3: nxt = 1;
                    default: nxt = 0;
                endcase
            end else begin
                nxt = p;
            end
            pat(nxt, rr, gg, bb);
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                tk = ($urandom_range(0, 3) == 0);
                step(tk, rr, gg, bb, "random");
            end
        end

        // Dwell saturation
        hold(4, 1'b0, 4'h0, 4'h0, 4'h0, "sat_off");
        hold(270, 1'b1, 4'h0, 4'h0, 4'h0, "sat_dwell");
        chk("sat", "dwell", {24'd0, dwell}, 32'd255);
        hold(4, 1'b0, 4'hF, 4'h0, 4'h0, "sat_red");
        chk("sat", "last_dwell", {24'd0, last_dwell}, 32'd255);

        // Error counter saturation via RED <-> INVALID ping-pong
        for (int i = 0; i < 130; i++) begin
            hold(4, 1'b0, 4'hF, 4'h0, 4'hF, "err_inv");
            hold(4, 1'b0, 4'hF, 4'h0, 4'h0, "err_red");
        end
        chk("sat", "err_cnt", {24'd0, err_cnt}, 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
